// File: rtl/continuous_monitoring_system_pkg.sv
// Shared constants and sizing helpers for the continuous monitoring system.
//   AXI_DATA_WIDTH : width of the wide trace packet produced by the monitor
//   DMA_DATA_WIDTH : beat width of the downstream AXI DMA / AXI-Stream FIFO
//   beats_for()    : ceiling division, narrow beats needed per wide packet
//   beat_idx_width(): counter width able to index every beat (at least 1 bit)
package continuous_monitoring_system_pkg;

    localparam int unsigned AXI_DATA_WIDTH = 200;
    localparam int unsigned DMA_DATA_WIDTH = 64;

    function automatic int unsigned beats_for(input int unsigned in_w, input int unsigned out_w);
        return (in_w + out_w - 1) / out_w;
    endfunction

    function automatic int unsigned beat_idx_width(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/cms_axis_downsizer.sv
// Wide-to-narrow AXI-Stream width converter for the monitor trace path.
// Captures one IN_WIDTH packet per S handshake and replays it as BEATS narrow beats,
// least-significant slice first; tlast is carried on the final beat only.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   S_AXIS_*             : wide input stream (tvalid/tready/tdata/tlast)
//   M_AXIS_*             : narrow output stream (tvalid/tready/tdata/tlast)
//   busy                 : a packet is held and not yet fully sent
//   beat_idx             : index of the beat currently presented on M_AXIS
//   pkt_count            : packets fully sent since reset, wraps at 2^32
module cms_axis_downsizer
    import continuous_monitoring_system_pkg::*;
#(
    parameter int unsigned  IN_WIDTH       = AXI_DATA_WIDTH,
    parameter int unsigned  OUT_WIDTH      = DMA_DATA_WIDTH,
    localparam int unsigned BEATS          = beats_for(IN_WIDTH, OUT_WIDTH),
    localparam int unsigned BEAT_IDX_WIDTH = beat_idx_width(BEATS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      S_AXIS_tvalid,
    output logic                      S_AXIS_tready,
    input  logic [IN_WIDTH-1:0]       S_AXIS_tdata,
    input  logic                      S_AXIS_tlast,
    output logic                      M_AXIS_tvalid,
    input  logic                      M_AXIS_tready,
    output logic [OUT_WIDTH-1:0]      M_AXIS_tdata,
    output logic                      M_AXIS_tlast,
    output logic                      busy,
    output logic [BEAT_IDX_WIDTH-1:0] beat_idx,
    output logic [31:0]               pkt_count
);

    localparam int unsigned PAD_WIDTH = BEATS * OUT_WIDTH;

    if ((OUT_WIDTH % 8) != 0) begin : gen_width_check
        $error("OUT_WIDTH must be a multiple of 8");
    end

    typedef enum logic {
        StEmpty,
        StSend
    } state_e;

    state_e                    state_q, state_d;
    logic [IN_WIDTH-1:0]       hold_q, hold_d;
    logic                      last_q, last_d;
    logic [BEAT_IDX_WIDTH-1:0] beat_idx_q, beat_idx_d;
    logic [31:0]               pkt_count_q, pkt_count_d;

    logic                      last_beat;
    logic [PAD_WIDTH-1:0]      hold_pad;

    assign last_beat = (beat_idx_q == BEAT_IDX_WIDTH'(BEATS - 1));

    // rst_n gates tready so it reads 0 while reset is held even though the
    // state register already sits in StEmpty.
    assign S_AXIS_tready = rst_n & ((state_q == StEmpty) | (last_beat & M_AXIS_tready));

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        last_d      = last_q;
        beat_idx_d  = beat_idx_q;
        pkt_count_d = pkt_count_q;
        unique case (state_q)
            StEmpty: begin
                if (S_AXIS_tvalid) begin
                    hold_d     = S_AXIS_tdata;
                    last_d     = S_AXIS_tlast;
                    beat_idx_d = '0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (M_AXIS_tready) begin
                    if (!last_beat) begin
                        beat_idx_d = beat_idx_q + 1'b1;
                    end else begin
                        pkt_count_d = pkt_count_q + 32'd1;
                        // Overlap the next capture with the final beat: no bubble.
                        if (S_AXIS_tvalid) begin
                            hold_d     = S_AXIS_tdata;
                            last_d     = S_AXIS_tlast;
                            beat_idx_d = '0;
                        end else begin
                            state_d = StEmpty;
                        end
                    end
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            hold_q      <= '0;
            last_q      <= 1'b0;
            beat_idx_q  <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            last_q      <= last_d;
            beat_idx_q  <= beat_idx_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Zero-extend so the top slice reads 0 above IN_WIDTH.
    assign hold_pad      = PAD_WIDTH'(hold_q);
    assign M_AXIS_tdata  = hold_pad[beat_idx_q * OUT_WIDTH +: OUT_WIDTH];
    assign M_AXIS_tvalid = (state_q == StSend);
    assign M_AXIS_tlast  = last_q & last_beat;
    assign busy          = (state_q == StSend);
    assign beat_idx      = beat_idx_q;
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_cms_axis_downsizer.sv
module tb_cms_axis_downsizer;

    localparam int unsigned IN_W  = 200;
    localparam int unsigned OUT_W = 64;
    localparam int unsigned NB    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_tvalid;
    logic              s_tready;
    logic [IN_W-1:0]   s_tdata;
    logic              s_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic [OUT_W-1:0]  m_tdata;
    logic              m_tlast;
    logic              busy;
    logic [1:0]        beat_idx;
    logic [31:0]       pkt_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_cnt  = 32'd0;
    int          hs_cyc[$];
    int          beat_cyc[$];

    always #5 clk = ~clk;

    cms_axis_downsizer #(
        .IN_WIDTH  (IN_W),
        .OUT_WIDTH (OUT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .S_AXIS_tvalid (s_tvalid),
        .S_AXIS_tready (s_tready),
        .S_AXIS_tdata  (s_tdata),
        .S_AXIS_tlast  (s_tlast),
        .M_AXIS_tvalid (m_tvalid),
        .M_AXIS_tready (m_tready),
        .M_AXIS_tdata  (m_tdata),
        .M_AXIS_tlast  (m_tlast),
        .busy          (busy),
        .beat_idx      (beat_idx),
        .pkt_count     (pkt_count)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_tready"}, 256'(s_tready), 256'd0);
        check({tag, "_m_tvalid"}, 256'(m_tvalid), 256'd0);
        check({tag, "_m_tdata"}, 256'(m_tdata), 256'd0);
        check({tag, "_m_tlast"}, 256'(m_tlast), 256'd0);
        check({tag, "_busy"}, 256'(busy), 256'd0);
        check({tag, "_beat_idx"}, 256'(beat_idx), 256'd0);
        check({tag, "_pkt_count"}, 256'(pkt_count), 256'd0);
    endtask

    function automatic logic [OUT_W-1:0] slice_of(input logic [IN_W-1:0] d, input int i);
        logic [NB*OUT_W-1:0] p;
        p = {56'd0, d};
        return p[i*OUT_W +: OUT_W];
    endfunction

    function automatic logic [IN_W-1:0] rand_pkt();
        logic [223:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[IN_W-1:0];
    endfunction

    // Streams n_pkts random packets through a scoreboard.
    // last_mode: 0 tlast=0, 1 tlast=1, 2 random. bp: random M_AXIS_tready.
    task automatic run_stream(input string tag, input int n_pkts, input bit bp,
                              input int last_mode);
        logic [OUT_W-1:0] q_data[$];
        logic             q_last[$];
        logic [1:0]       q_idx[$];
        int               offered = 0;
        int               rcvd    = 0;
        int               cyc     = 0;
        int               total   = n_pkts * NB;
        bit               s_fired = 1'b0;
        bit               stall   = 1'b0;
        logic [OUT_W-1:0] p_data;
        logic [1:0]       p_idx;
        logic             p_last;
        hs_cyc.delete();
        beat_cyc.delete();
        while (rcvd < total && cyc < total * 16 + 64) begin
            @(negedge clk);
            if (s_fired) s_tvalid = 1'b0;
            if (!s_tvalid && offered < n_pkts) begin
                s_tvalid = 1'b1;
                s_tdata  = rand_pkt();
                s_tlast  = (last_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(last_mode);
                offered++;
            end
            m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (m_tvalid) begin
                if (stall) begin
                    check({tag, "_hold_data"}, 256'(m_tdata), 256'(p_data));
                    check({tag, "_hold_idx"}, 256'(beat_idx), 256'(p_idx));
                    check({tag, "_hold_last"}, 256'(m_tlast), 256'(p_last));
                end
                if (m_tready) begin
                    if (q_data.size() == 0) begin
                        check({tag, "_extra_beat"}, 256'(1), 256'(0));
                    end else begin
                        check({tag, "_data"}, 256'(m_tdata), 256'(q_data.pop_front()));
                        check({tag, "_last"}, 256'(m_tlast), 256'(q_last.pop_front()));
                        check({tag, "_idx"}, 256'(beat_idx), 256'(q_idx.pop_front()));
                    end
                    rcvd++;
                    beat_cyc.push_back(cyc);
                end
            end
            stall  = m_tvalid && !m_tready;
            p_data = m_tdata;
            p_idx  = beat_idx;
            p_last = m_tlast;
            s_fired = s_tvalid && s_tready;
            if (s_fired) begin
                for (int i = 0; i < NB; i++) begin
                    q_data.push_back(slice_of(s_tdata, i));
                    q_last.push_back(s_tlast && (i == NB - 1));
                    q_idx.push_back(2'(i));
                end
                hs_cyc.push_back(cyc);
            end
            cyc++;
        end
        if (rcvd < total) check({tag, "_timeout"}, 256'(rcvd), 256'(total));
        s_tvalid = 1'b0;
        exp_cnt  = exp_cnt + 32'(n_pkts);
        @(negedge clk);
        #1;
        check({tag, "_pkt_count"}, 256'(pkt_count), 256'(exp_cnt));
        check({tag, "_busy_end"}, 256'(busy), 256'd0);
        check({tag, "_valid_end"}, 256'(m_tvalid), 256'd0);
    endtask

    logic [IN_W-1:0]  d1;
    logic [OUT_W-1:0] d1_beats[NB];

    initial begin
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        d1 = {8'h0A, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444};
        d1_beats[0] = 64'h4444444444444444;
        d1_beats[1] = 64'h3333333333333333;
        d1_beats[2] = 64'h2222222222222222;
        d1_beats[3] = 64'h000000000000000A;

        // Reset values.
        #3;
        check_all_zero("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_tready", 256'(s_tready), 256'd1);

        // Single packet, continuous downstream ready.
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = d1;
        s_tlast  = 1'b1;
        m_tready = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            #1;
            check("sp_valid", 256'(m_tvalid), 256'd1);
            check("sp_data", 256'(m_tdata), 256'(d1_beats[i]));
            check("sp_last", 256'(m_tlast), 256'(i == NB - 1));
            check("sp_idx", 256'(beat_idx), 256'(i));
            check("sp_s_tready", 256'(s_tready), 256'(i == NB - 1));
            check("sp_busy", 256'(busy), 256'd1);
            @(negedge clk);
        end
        #1;
        exp_cnt = 32'd1;
        check("sp_pkt_count", 256'(pkt_count), 256'(exp_cnt));
        check("sp_busy_end", 256'(busy), 256'd0);
        check("sp_valid_end", 256'(m_tvalid), 256'd0);

        // Back-to-back packets: no bubble between packets.
        run_stream("b2b", 3, 1'b0, 1);
        check("b2b_hs_count", 256'(hs_cyc.size()), 256'd3);
        check("b2b_beats", 256'(beat_cyc.size()), 256'd12);
        if (hs_cyc.size() == 3) begin
            check("b2b_hs1", 256'(hs_cyc[1] - hs_cyc[0]), 256'd4);
            check("b2b_hs2", 256'(hs_cyc[2] - hs_cyc[0]), 256'd8);
        end
        if (beat_cyc.size() == 12) begin
            check("b2b_span", 256'(beat_cyc[11] - beat_cyc[0]), 256'd11);
            check("b2b_first_lat", 256'(beat_cyc[0] - hs_cyc[0]), 256'd1);
        end

        // tlast=0 packets keep every beat's tlast low but still count.
        run_stream("nolast", 2, 1'b0, 0);

        // Random backpressure across many packets.
        run_stream("bp", 100, 1'b1, 2);

        // Reset mid-packet, after beats 0 and 1 are accepted.
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = d1;
        s_tlast  = 1'b1;
        m_tready = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid_idx_before_rst", 256'(beat_idx), 256'd2);
        m_tready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        exp_cnt = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_release_tready", 256'(s_tready), 256'd1);
        check("mid_rst_no_remnant", 256'(m_tvalid), 256'd0);
        run_stream("after_rst", 1, 1'b0, 1);

        // Counter wrap from all-ones.
        @(negedge clk);
        force dut.pkt_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.pkt_count_q;
        exp_cnt = 32'hFFFF_FFFF;
        #1;
        check("wrap_busy_pre", 256'(busy), 256'd0);
        check("wrap_valid_pre", 256'(m_tvalid), 256'd0);
        run_stream("wrap", 1, 1'b0, 1);
        check("wrap_zero", 256'(pkt_count), 256'd0);
        check("wrap_idx", 256'(beat_idx), 256'(NB - 1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
